// File: rtl/mux_by_buf_pkg.sv
// Shared constants for mux_by_buf and its per-bit structural gate.
//   RST_BIT  : reset value of the 1-bit registers (s_q, oe_q, err)
//   RST_DATA : reset value of the data registers (a_q, b_q)
//   ALL_Z    : released-bus constant, sliced down to WIDTH by users
//   MAX_WIDTH: widest data path the constants above cover
package mux_by_buf_pkg;

    localparam int                     MAX_WIDTH = 64;
    localparam logic                   RST_BIT   = 1'b0;
    localparam logic [MAX_WIDTH-1:0]   RST_DATA  = '0;
    localparam logic [MAX_WIDTH-1:0]   ALL_Z     = {MAX_WIDTH{1'bz}};

endpackage

// File: rtl/mux_by_buf_gate.sv
// mux2_oe_gate: one bit of the structural mux path. Two enable-controlled
// buffers share a single resolved net; with neither enable high the net
// floats to Z.
//   i_a, i_b       : data driven by buffer A / buffer B
//   i_en_a, i_en_b : buffer enables (never both high in normal use)
//   o_w            : resolved net
module mux2_oe_gate (
    input  logic i_a,
    input  logic i_b,
    input  logic i_en_a,
    input  logic i_en_b,
    output wire  o_w
);

    // NOTE: two continuous drivers on one wire are intentional here; the net
    // resolves like a real bus, so a fight between buffers shows up as X.
    assign o_w = i_en_a ? i_a : 1'bz;
    assign o_w = i_en_b ? i_b : 1'bz;

endmodule

// File: rtl/mux_by_buf.sv
// mux_by_buf: registered 2:1 tri-state mux with a built-in self-check.
// Inputs are registered once; the registered values feed both a
// behavioural mux expression (which drives the output) and a structural
// per-bit buffer network. Any bitwise disagreement between the two paths
// sets a sticky error flag.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   a   : data selected when s=0      b : data selected when s=1
//   s   : select                      oe: active-high output enable
//   w   : tri-state mux output (one cycle after inputs)
//   hiz : high while w is released
//   err : sticky path-mismatch flag, cleared only by reset
module mux_by_buf
    import mux_by_buf_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             oe,
    output wire  [WIDTH-1:0] w,
    output logic             hiz,
    output logic             err
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s;
    logic             r_oe;
    logic             r_err;

    wire  [WIDTH-1:0] w_gate;
    wire  [WIDTH-1:0] w_beh;
    logic             w_mismatch;

    // Registering the select together with the data means a select change
    // with equal data never exposes an intermediate X or Z on w.
    // NOTE: reset is sampled on the clock edge and has priority over both
    // sampling and error capture in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= RST_DATA[WIDTH-1:0];
            r_b  <= RST_DATA[WIDTH-1:0];
            r_s  <= RST_BIT;
            r_oe <= RST_BIT;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value regardless of statement order.
            r_a  <= a;
            r_b  <= b;
            r_s  <= s;
            r_oe <= oe;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            mux2_oe_gate u_gate (
                .i_a    (r_a[gi]),
                .i_b    (r_b[gi]),
                .i_en_a (r_oe & ~r_s),
                .i_en_b (r_oe &  r_s),
                .o_w    (w_gate[gi])
            );
        end
    endgenerate

    assign w_beh = r_oe ? (r_s ? r_b : r_a) : ALL_Z[WIDTH-1:0];

    // NOTE: case inequality, so Z and X are compared as values rather than
    // collapsing the whole comparison to X.
    assign w_mismatch = (w_gate !== w_beh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= RST_BIT;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign w   = w_beh;
    assign hiz = ~r_oe;
    assign err = r_err;

endmodule

// File: tb/tb_mux_by_buf.sv
// Self-checking bench for mux_by_buf (WIDTH=8). The driver applies one
// input vector per cycle and pushes the response expected after the next
// rising edge; the monitor pops and compares after every rising edge.
module tb_mux_by_buf;
    import mux_by_buf_pkg::*;

    localparam int W = 8;
    localparam logic [W-1:0] WZ = ALL_Z[W-1:0];

    typedef struct {
        logic         is_z;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         oe;
    wire  [W-1:0] w;
    logic         hiz;
    logic         err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    mux_by_buf #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .oe  (oe),
        .w   (w),
        .hiz (hiz),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic ok,
                         input string act, input string req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    // Reference model: output after the edge depends only on the vector
    // presented before that edge.
    task automatic step(input string name, input logic r,
                        input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vs, input logic voe);
        exp_t e;
        @(negedge clk);
        rst = r; a = va; b = vb; s = vs; oe = voe;
        e.name = name;
        e.is_z = r || !voe;
        e.val  = vs ? vb : va;
        sb_q.push_back(e);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = sb_q.pop_front();
            if (e.is_z) begin
                ok = (w === WZ);
                check({e.name, "_w"}, ok, $sformatf("%h", w), "zz");
                check({e.name, "_hiz"}, hiz === 1'b1, $sformatf("%b", hiz), "1");
            end else begin
                ok = (w === e.val);
                check({e.name, "_w"}, ok, $sformatf("%h", w), $sformatf("%h", e.val));
                check({e.name, "_hiz"}, hiz === 1'b0, $sformatf("%b", hiz), "0");
            end
            check({e.name, "_err"}, err === 1'b0, $sformatf("%b", err), "0");
        end
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; s = 1'b0; oe = 1'b0;

        // Reset held for two edges with all inputs high.
        step("rst0", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        step("rst1", 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        step("rel",  1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        // {a,b,s,oe} patterns, each bit replicated across the byte.
        step("p1011", 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
        step("p1001", 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1);
        step("p1011b", 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
        step("p1111", 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        // Select change with equal data: w must stay all ones.
        step("haz0", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        step("haz1", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        step("p1100", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        // Width test: toggling select, reset asserted mid-sequence.
        for (int i = 0; i < 6; i++)
            step($sformatf("tog%0d", i), 1'b0, 8'hA5, 8'h3C, i[0], 1'b1);
        step("midrst", 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);
        step("post",   1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 300; i++)
            step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0),
                 W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clk);
        check("drain", sb_q.size() == 0, $sformatf("%0d left", sb_q.size()), "0 left");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
